// File: rtl/serial_to_parallel_rx_if.sv
// Bundle of serial input, framing strobe, buffered word output and error pulses
// for serial_to_parallel_rx; master is the receiver, slave is its environment.
interface serial_to_parallel_rx_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             sync_err;
    logic             overflow;
    logic             parity_err;

    modport master (
        input  sin, sync, dout_ready,
        output dout, dout_valid, sync_err, overflow, parity_err
    );

    modport slave (
        output sin, sync, dout_ready,
        input  dout, dout_valid, sync_err, overflow, parity_err
    );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Framed serial receiver: MSB-first deserialiser feeding a 2-entry valid/ready buffer.
// Define SER_RX_PARITY_CHK_EN to expect and check a trailing even-parity bit per frame.
//
// state | meaning
// HUNT  | idle between frames, waiting for sync to mark an MSB
// SHIFT | collecting bits of the current frame, cnt = bits already taken
module serial_to_parallel_rx #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    serial_to_parallel_rx_if.master bus
);
`ifdef SER_RX_PARITY_CHK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME) + 1;

    typedef enum logic {HUNT, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [FRAME-1:0] shreg, shreg_nxt;
    logic [FRAME-1:0] frame_full;
    logic [WIDTH-1:0] word;
    logic             frame_done;
    logic             parity_ok;
    logic             push;
    logic             pop;
    logic             sync_err_nxt;
    logic             overflow_nxt;
    logic             sync_err_q;
    logic             overflow_q;
    logic [WIDTH-1:0] head, tail;
    logic [1:0]       fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            cnt        <= '0;
            shreg      <= '0;
            sync_err_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            sync_err_q <= sync_err_nxt;
            overflow_q <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shreg_nxt    = shreg;
        frame_done   = 1'b0;
        sync_err_nxt = 1'b0;
        frame_full   = {shreg[FRAME-2:0], bus.sin};
        case (state)
            HUNT: begin
                if (bus.sync) begin
                    shreg_nxt = {{(FRAME-1){1'b0}}, bus.sin};
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // sync mid-frame restarts the frame on the current bit
                if (bus.sync) begin
                    sync_err_nxt = 1'b1;
                    shreg_nxt    = {{(FRAME-1){1'b0}}, bus.sin};
                    cnt_nxt      = CNT_W'(1);
                end else begin
                    shreg_nxt = frame_full;
                    if (cnt == CNT_W'(FRAME - 1)) begin
                        frame_done = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = HUNT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

`ifdef SER_RX_PARITY_CHK_EN
    logic parity_err_q;

    assign word      = frame_full[FRAME-1:1];
    assign parity_ok = ~^frame_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) parity_err_q <= 1'b0;
        else      parity_err_q <= frame_done & ~parity_ok;
    end

    assign bus.parity_err = parity_err_q;
`else
    assign word           = frame_full[WIDTH-1:0];
    assign parity_ok      = 1'b1;
    assign bus.parity_err = 1'b0;
`endif

    assign push         = frame_done & parity_ok;
    assign pop          = bus.dout_valid & bus.dout_ready;
    assign overflow_nxt = push & (fill == 2'd2) & ~pop;

    // head is the visible entry; a simultaneous pop frees room for the push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            fill <= '0;
        end else begin
            if (pop && push) begin
                if (fill == 2'd2) begin
                    head <= tail;
                    tail <= word;
                end else begin
                    head <= word;
                end
            end else if (pop) begin
                head <= tail;
                fill <= fill - 2'd1;
            end else if (push && fill != 2'd2) begin
                if (fill == 2'd0) head <= word;
                else              tail <= word;
                fill <= fill + 2'd1;
            end
        end
    end

    assign bus.dout       = head;
    assign bus.dout_valid = (fill != 2'd0);
    assign bus.sync_err   = sync_err_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx (WIDTH=4); parity steps replace the
// framing steps when SER_RX_PARITY_CHK_EN is defined.
module tb_serial_to_parallel_rx;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_to_parallel_rx_if #(.WIDTH(4)) bus();

    serial_to_parallel_rx #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b);
        bus.sync = s;
        bus.sin  = b;
        tick();
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) drive(i == 3, w[i]);
        bus.sync = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bus.sin        = 1'b0;
        bus.sync       = 1'b0;
        bus.dout_ready = 1'b0;
        tick();
        tick();
        check("rst_dout", 16'(bus.dout), 16'h0);
        check("rst_valid", 16'(bus.dout_valid), 16'h0);
        check("rst_sync_err", 16'(bus.sync_err), 16'h0);
        check("rst_overflow", 16'(bus.overflow), 16'h0);
        check("rst_parity_err", 16'(bus.parity_err), 16'h0);
        rst = 1'b1;
        tick();

`ifdef SER_RX_PARITY_CHK_EN
        bus.dout_ready = 1'b1;
        drive(1, 1); drive(0, 0); drive(0, 1); drive(0, 1); drive(0, 1);
        check("par_ok_valid", 16'(bus.dout_valid), 16'h1);
        check("par_ok_dout", 16'(bus.dout), 16'hB);
        check("par_ok_err", 16'(bus.parity_err), 16'h0);
        drive(0, 0);
        check("par_ok_popped", 16'(bus.dout_valid), 16'h0);
        drive(1, 1); drive(0, 0); drive(0, 1); drive(0, 1); drive(0, 0);
        check("par_bad_err", 16'(bus.parity_err), 16'h1);
        check("par_bad_valid", 16'(bus.dout_valid), 16'h0);
        check("par_bad_ovf", 16'(bus.overflow), 16'h0);
        drive(0, 0);
        check("par_err_pulse", 16'(bus.parity_err), 16'h0);
        check("par_bad_still_empty", 16'(bus.dout_valid), 16'h0);
`else
        // single word
        bus.dout_ready = 1'b1;
        drive(1, 1); drive(0, 0); drive(0, 1); drive(0, 1);
        check("single_valid", 16'(bus.dout_valid), 16'h1);
        check("single_dout", 16'(bus.dout), 16'hB);
        drive(0, 0);
        check("single_one_cycle", 16'(bus.dout_valid), 16'h0);

        // back-to-back frames
        send_word(4'hB);
        check("b2b_w0", 16'(bus.dout), 16'hB);
        check("b2b_w0_valid", 16'(bus.dout_valid), 16'h1);
        send_word(4'h6);
        check("b2b_w1", 16'(bus.dout), 16'h6);
        check("b2b_w1_valid", 16'(bus.dout_valid), 16'h1);
        check("b2b_w1_sync_err", 16'(bus.sync_err), 16'h0);
        send_word(4'h1);
        check("b2b_w2", 16'(bus.dout), 16'h1);
        check("b2b_w2_sync_err", 16'(bus.sync_err), 16'h0);
        drive(0, 0);
        check("b2b_drained", 16'(bus.dout_valid), 16'h0);

        // backpressure and overflow
        bus.dout_ready = 1'b0;
        send_word(4'hB);
        check("bp_first", 16'(bus.dout), 16'hB);
        send_word(4'h6);
        check("bp_hold", 16'(bus.dout), 16'hB);
        check("bp_no_ovf", 16'(bus.overflow), 16'h0);
        send_word(4'h1);
        check("bp_ovf", 16'(bus.overflow), 16'h1);
        check("bp_head_kept", 16'(bus.dout), 16'hB);
        bus.dout_ready = 1'b1;
        drive(0, 0);
        check("bp_ovf_pulse", 16'(bus.overflow), 16'h0);
        check("bp_second", 16'(bus.dout), 16'h6);
        check("bp_second_valid", 16'(bus.dout_valid), 16'h1);
        drive(0, 0);
        check("bp_empty", 16'(bus.dout_valid), 16'h0);

        // misalignment
        drive(1, 1); drive(0, 0);
        drive(1, 0);
        check("mis_sync_err", 16'(bus.sync_err), 16'h1);
        check("mis_no_partial", 16'(bus.dout_valid), 16'h0);
        drive(0, 1);
        check("mis_pulse", 16'(bus.sync_err), 16'h0);
        drive(0, 0); drive(0, 1);
        check("mis_valid", 16'(bus.dout_valid), 16'h1);
        check("mis_dout", 16'(bus.dout), 16'h5);
        drive(0, 0);

        // reset mid-operation
        bus.dout_ready = 1'b0;
        send_word(4'h6);
        check("rstmid_buffered", 16'(bus.dout_valid), 16'h1);
        drive(1, 1); drive(0, 1);
        bus.sync = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_valid", 16'(bus.dout_valid), 16'h0);
        check("rstmid_dout", 16'(bus.dout), 16'h0);
        tick();
        rst = 1'b1;
        bus.dout_ready = 1'b1;
        tick();
        send_word(4'h9);
        check("rstmid_after_valid", 16'(bus.dout_valid), 16'h1);
        check("rstmid_after_dout", 16'(bus.dout), 16'h9);
        check("rstmid_after_sync_err", 16'(bus.sync_err), 16'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Receive side of the framed serial link.
- Samples a 1-bit serial stream, MSB first. A sync strobe marks the first (MSB) bit of each word.
- Reassembles the bits into WIDTH-bit words and hands them downstream through a 2-entry valid/ready output buffer.
- Detects frame misalignment and buffer overflow.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit, sampled every clk edge.
- sync  input  1  high in the same cycle as the MSB of a word.
- dout  output  WIDTH  head word of the output buffer.
- dout_valid  output  1  dout holds a valid word.
- dout_ready  input  1  downstream accepts dout this cycle.
- sync_err  output  1  one-cycle pulse: sync arrived mid-word.
- overflow  output  1  one-cycle pulse: completed word dropped because the buffer was full.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when the optional feature is out.

Behaviour:
- Reset: clock is one clk; reset is asynchronous, active-low on rst.
  - While rst=0: state=HUNT, bit counter=0, shift register=0, buffer empty.
  - All outputs 0 (dout=0, dout_valid=0, sync_err=0, overflow=0, parity_err=0).
  - Reset mid-word discards the partial word and all buffered words.
- HUNT state:
  - sin is ignored while sync=0.
  - sync=1: capture sin as the MSB, set counter=1, go to SHIFT.
- SHIFT state:
  - Each cycle: shift sin in at the LSB side, counter+1.
  - If sync=1 while counter is not 0: pulse sync_err the next cycle, discard the partial word, treat the current bit as a new MSB, counter=1.
  - When the last bit (counter=FRAME-1) is sampled, the word is complete and is pushed to the buffer at that edge.
  - FRAME=WIDTH, or WIDTH+1 with the optional feature.
- Cycle after completion:
  - sync=1: start a new word (back-to-back, no gap, no error).
  - sync=0: return to HUNT; gaps between frames are legal.
- Latency: dout_valid rises on the edge that samples the last bit, i.e. visible the cycle after the last bit is on sin, when the buffer was empty.
- Output buffer: 2-entry FIFO, first in first out.
  - Pop on dout_valid & dout_ready.
  - dout and dout_valid are registered; dout is stable while dout_valid=1 and dout_ready=0.
- Push while full:
  - Push with 2 entries and no pop in the same cycle: the new word is dropped, overflow pulses for one cycle, the buffered words are kept.
  - Push and pop in the same cycle while full: the push is accepted, no overflow.
- Simultaneous sync_err and a push of a just-completed word cannot occur, because a word completes before the next sync is legal.
- Bit order: the first received bit lands in dout[WIDTH-1]. The counter wraps only via the rules above, never modulo-free-running.

Optional Feature:
- Macro name: SER_RX_PARITY_CHK_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the LSB (FRAME=WIDTH+1).
  - Parity is checked when the frame completes.
  - Mismatch: the word is not pushed, parity_err pulses one cycle, overflow is not asserted.
  - Match: the word is pushed as normal.
- Not defined: FRAME=WIDTH, no parity logic, parity_err held at 0.

Test Plan (WIDTH=4, macro off unless stated):
- Single word: sync=1 with sin=1, then sin=0,1,1; dout_ready=1 → cycle after the 4th bit dout=4'hB, dout_valid=1 for 1 cycle.
- Back-to-back: 0xB, 0x6, 0x1, sync every 4 cycles, ready=1 → three words out, 4 cycles apart, no sync_err.
- Backpressure: ready=0 while 0xB, 0x6, 0x1 are sent → overflow pulses once at 0x1 completion. Then ready=1 → 0xB then 0x6 on consecutive cycles, buffer empty.
- Misalignment: sync, then 2 bits, then sync again with bits 0,1,0,1 → sync_err=1 for one cycle, partial word dropped, dout=4'h5.
- Reset mid-operation: rst=0 after 2 bits with one word buffered → dout_valid=0 and dout=0 immediately. After release, the next full frame 0x9 outputs correctly.
- Parity (macro on): frame 1,0,1,1,p=1 → 0xB delivered. Same frame with p=0 → parity_err pulse, no dout_valid.
